// File: rtl/pwm_umbral_decoder_if.sv
// Bundle between a PWM threshold generator line and its decoder.
// The master drives the PWM line; the slave publishes the recovered threshold.
interface pwm_umbral_decoder_if #(
  parameter int WIDTH = 12
);
  logic             i_pwm;
  logic [WIDTH-1:0] o_umbral;
  logic             o_valid;
  logic             o_locked;
  logic             o_err;

  modport master (
    output i_pwm,
    input  o_umbral, o_valid, o_locked, o_err
  );

  modport slave (
    input  i_pwm,
    output o_umbral, o_valid, o_locked, o_err
  );
endinterface

// File: rtl/pwm_umbral_decoder.sv
// Recovers the threshold of a free-running PWM generator by timing each low phase,
// with stuck-low (threshold 0) detection and a stuck-high error flag.
module pwm_umbral_decoder #(
  parameter int WIDTH       = 12,
  parameter int SYNC_STAGES = 2
) (
  input logic                 clock,
  input logic                 i_reset_n,
  pwm_umbral_decoder_if.slave bus
);

  localparam logic [WIDTH-1:0] CntMax = '1;

  typedef enum logic [1:0] {IDLE, LOW, HIGH} stateT;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sPrev_q;
  stateT                  state_q, state_d;
  logic [WIDTH-1:0]       lowCnt_q, lowCnt_d;
  logic [WIDTH-1:0]       highCnt_q, highCnt_d;
  logic [WIDTH-1:0]       umbral_q, umbral_d;
  logic                   valid_q, valid_d;
  logic                   locked_q, locked_d;
  logic                   err_q, err_d;

  logic                   sPwm, fall, rise;
  logic                   emit;
  logic [WIDTH-1:0]       emitVal;

  assign sPwm = sync_q[SYNC_STAGES-1];
  assign fall = sPrev_q & ~sPwm;
  assign rise = ~sPrev_q & sPwm;

  always_ff @(posedge clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync_q    <= '0;
      sPrev_q   <= 1'b0;
      state_q   <= IDLE;
      lowCnt_q  <= '0;
      highCnt_q <= '0;
      umbral_q  <= '0;
      valid_q   <= 1'b0;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], bus.i_pwm};
      sPrev_q   <= sPwm;
      state_q   <= state_d;
      lowCnt_q  <= lowCnt_d;
      highCnt_q <= highCnt_d;
      umbral_q  <= umbral_d;
      valid_q   <= valid_d;
      locked_q  <= locked_d;
      err_q     <= err_d;
    end
  end

  // IDLE only arms on a falling edge so a partial low phase is never reported;
  // a full period of low wraps the counter and reports threshold 0 instead.
  always_comb begin
    state_d   = state_q;
    lowCnt_d  = lowCnt_q;
    highCnt_d = highCnt_q;
    emit      = 1'b0;
    emitVal   = '0;

    case (state_q)
      IDLE: begin
        if (fall) begin
          lowCnt_d = WIDTH'(1);
          state_d  = LOW;
        end else if (!sPwm) begin
          if (lowCnt_q == CntMax) begin
            emit     = 1'b1;
            lowCnt_d = '0;
            state_d  = LOW;
          end else begin
            lowCnt_d = lowCnt_q + WIDTH'(1);
          end
        end else begin
          lowCnt_d = '0;
        end
      end
      LOW: begin
        if (rise) begin
          emit      = 1'b1;
          emitVal   = lowCnt_q;
          highCnt_d = WIDTH'(1);
          state_d   = HIGH;
        end else if (!sPwm) begin
          if (lowCnt_q == CntMax) begin
            emit     = 1'b1;
            lowCnt_d = '0;
          end else begin
            lowCnt_d = lowCnt_q + WIDTH'(1);
          end
        end
      end
      HIGH: begin
        if (fall) begin
          lowCnt_d  = WIDTH'(1);
          highCnt_d = '0;
          state_d   = LOW;
        end else if (sPwm && (highCnt_q != CntMax)) begin
          highCnt_d = highCnt_q + WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    valid_d  = emit;
    umbral_d = emit ? emitVal : umbral_q;
    locked_d = locked_q | emit;
    if (emit) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q | ((state_q == HIGH) && (highCnt_d == CntMax));
    end
  end

  assign bus.o_umbral = umbral_q;
  assign bus.o_valid  = valid_q;
  assign bus.o_locked = locked_q;
  assign bus.o_err    = err_q;

endmodule

// File: tb/tb_pwm_umbral_decoder.sv
// Drives a PWM generator model into pwm_umbral_decoder and scoreboards every o_valid
// against the threshold (and spacing) expected from the driven waveform.
module tb_pwm_umbral_decoder;

  localparam int Width      = 12;
  localparam int SyncStages = 2;
  localparam int Period     = 1 << Width;

  typedef struct {
    int lowLen;
    int highLen;
    int expVal;
  } vecT;

  typedef struct {
    int value;
    int gap;
  } expT;

  logic clock;
  logic rstN;
  int   tests;
  int   fails;
  int   cyc;
  int   lastValid;
  int   prevValid;
  expT  sb[$];
  expT  monE;
  expT  pushE;
  vecT  tbl[9];

  pwm_umbral_decoder_if #(.WIDTH(Width)) bus ();

  pwm_umbral_decoder #(
    .WIDTH      (Width),
    .SYNC_STAGES(SyncStages)
  ) dut (
    .clock    (clock),
    .i_reset_n(rstN),
    .bus      (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Holds the PWM line at one level for n rising edges.
  task automatic applyStimulus(input logic level, input int n);
    repeat (n) begin
      @(negedge clock);
      bus.i_pwm = level;
    end
  endtask

  task automatic pushExp(input int value, input int gap);
    pushE.value = value;
    pushE.gap   = gap;
    sb.push_back(pushE);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_umbral"}, int'(bus.o_umbral), 0);
    checkOutput({tag, "_valid"},  int'(bus.o_valid),  0);
    checkOutput({tag, "_locked"}, int'(bus.o_locked), 0);
    checkOutput({tag, "_err"},    int'(bus.o_err),    0);
  endtask

  // Every o_valid pops one expectation; spacing is checked in cycles between pulses.
  always @(posedge clock) begin
    #1;
    cyc++;
    if (bus.o_valid) begin
      checkOutput("validWidth", prevValid, 0);
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL unexpectedValid: got o_umbral=%0d, expected no pulse", bus.o_umbral);
      end else begin
        monE = sb.pop_front();
        checkOutput("umbral", int'(bus.o_umbral), monE.value);
        checkOutput("lockedOnValid", int'(bus.o_locked), 1);
        if (monE.gap > 0) checkOutput("validGap", cyc - lastValid, monE.gap);
      end
      lastValid = cyc;
    end
    prevValid = int'(bus.o_valid);
  end

  initial begin
    int gap;
    int lat;

    tests     = 0;
    fails     = 0;
    cyc       = 0;
    lastValid = 0;
    prevValid = 0;
    rstN      = 1'b0;
    bus.i_pwm = 1'b0;

    // Steady 100, then 4095 -> 1, then 100 -> 2000 switched at counter 1000 (transitional 1000).
    tbl[0] = '{100,  3996, 100};
    tbl[1] = '{100,  3996, 100};
    tbl[2] = '{100,  3996, 100};
    tbl[3] = '{4095, 1,    4095};
    tbl[4] = '{1,    4095, 1};
    tbl[5] = '{100,  900,  100};
    tbl[6] = '{1000, 2096, 1000};
    tbl[7] = '{2000, 2096, 2000};
    tbl[8] = '{2000, 2096, 2000};

    repeat (3) @(negedge clock);
    checkResetOutputs("powerOnReset");

    // Threshold 0: constant low from reset reports 0 every full period.
    pushExp(0, 0);
    pushExp(0, Period);
    rstN = 1'b1;
    applyStimulus(1'b0, 2 * Period + 8);
    checkOutput("stuckLowLocked", int'(bus.o_locked), 1);

    // Reset released mid-high, then the vector table.
    @(negedge clock);
    rstN      = 1'b0;
    bus.i_pwm = 1'b1;
    #1;
    checkResetOutputs("resetAfterStuckLow");
    repeat (3) @(negedge clock);
    rstN = 1'b1;
    applyStimulus(1'b1, 1000);

    for (int i = 0; i < 9; i++) begin
      gap = (i == 0) ? 0 : tbl[i-1].highLen + tbl[i].lowLen;
      pushExp(tbl[i].expVal, gap);
      applyStimulus(1'b0, tbl[i].lowLen);
      applyStimulus(1'b1, tbl[i].highLen);
    end
    checkOutput("tableErr", int'(bus.o_err), 0);

    // Stuck high for 5000 cycles after lock, then a 300-cycle low phase.
    pushExp(2000, tbl[8].highLen + 2000);
    applyStimulus(1'b0, 2000);
    applyStimulus(1'b1, 4090);
    @(posedge clock);
    #1;
    checkOutput("errBeforeLimit", int'(bus.o_err), 0);
    applyStimulus(1'b1, 9);
    @(posedge clock);
    #1;
    checkOutput("errAtLimit", int'(bus.o_err), 1);
    applyStimulus(1'b1, 901);
    checkOutput("errHeld", int'(bus.o_err), 1);
    pushExp(300, 5000 + 300);
    applyStimulus(1'b0, 300);
    checkOutput("errDuringLow", int'(bus.o_err), 1);

    // Edges from a negedge line change to o_valid; a generator updating on the
    // rising edge adds that edge, giving SYNC_STAGES+2 counted from it.
    @(negedge clock);
    bus.i_pwm = 1'b1;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clock);
      #1;
      if (bus.o_valid) begin
        lat = k;
        break;
      end
    end
    checkOutput("riseToValidLatency", lat, SyncStages + 1);
    checkOutput("errClearedOnValid", int'(bus.o_err), 0);
    checkOutput("umbralAfterErr", int'(bus.o_umbral), 300);
    applyStimulus(1'b1, 3000);

    // Reset mid low phase: the remaining partial low must not be reported.
    applyStimulus(1'b0, 200);
    @(negedge clock);
    rstN = 1'b0;
    #1;
    checkResetOutputs("resetMidLow");
    repeat (5) @(negedge clock);
    rstN = 1'b1;
    applyStimulus(1'b0, 500);
    applyStimulus(1'b1, 3596);
    checkOutput("noPartialLocked", int'(bus.o_locked), 0);
    pushExp(700, 0);
    applyStimulus(1'b0, 700);
    applyStimulus(1'b1, 50);
    checkOutput("postResetUmbral", int'(bus.o_umbral), 700);
    checkOutput("drainScoreboard", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pwm_umbral_decoder.md
Name: pwm_umbral_decoder

Overview:
- Receive end of the free-running PWM threshold generator: samples the generator's single-bit PWM output and recovers the 12-bit threshold that produced it.
- Generator contract decoded here:
  - the period is 2**WIDTH clocks;
  - the output is low for exactly `umbral` clocks after the counter wraps, then high for the remainder of the period;
  - `umbral` = 0 gives a constant low.
- Used on boards that receive the PWM line from another clock domain or device. Publishes the recovered value with a valid strobe, plus lock and stuck-high status.

Parameters:
- WIDTH, 12, threshold / counter width; nominal period = 2**WIDTH clocks.
- SYNC_STAGES, 2, flip-flops in the input synchronizer (minimum 2).

Ports:
- clock, input, 1, single system clock; all logic on rising edge.
- i_reset_n, input, 1, asynchronous active-low reset.
- i_pwm, input, 1, PWM line from the generator; asynchronous to `clock`.
- o_umbral, output, WIDTH, last recovered threshold.
- o_valid, output, 1, one-cycle pulse when `o_umbral` is updated.
- o_locked, output, 1, high once at least one measurement has been produced.
- o_err, output, 1, stuck-high flag.

Behaviour:
- **Clock and reset (already decided):** one clock, `clock`. `i_reset_n` is asynchronous and active-low.
- **Reset values:**
  - all synchronizer flops = 0; previous-sample register `s_prev` = 0;
  - FSM = IDLE; counters = 0;
  - `o_umbral` = 0, `o_valid` = 0, `o_locked` = 0, `o_err` = 0.
- **Synchronizer and edge detect:**
  - `i_pwm` passes through SYNC_STAGES flops to give `s_pwm`; `s_prev` holds `s_pwm` delayed one cycle.
  - fall = `s_prev` & ~`s_pwm`; rise = ~`s_prev` & `s_pwm`.
- **Low counter `low_cnt`** (WIDTH bits) and **high counter `high_cnt`** (WIDTH bits, saturating at all-ones).
- **FSM state IDLE** (no valid phase reference yet):
  - Rise edges are ignored.
  - On fall: `low_cnt` <= 1, go to LOW.
  - While `s_pwm` = 0 and not fall: `low_cnt` increments.
  - When `low_cnt` = 2**WIDTH-1 with `s_pwm` still 0 (i.e. 2**WIDTH consecutive low cycles): emit measurement 0, `low_cnt` <= 0, go to LOW.
  - While `s_pwm` = 1: `low_cnt` <= 0.
- **FSM state LOW:**
  - Each cycle with `s_pwm` = 0: `low_cnt` <= `low_cnt` + 1.
  - When `low_cnt` = 2**WIDTH-1 and `s_pwm` = 0: emit measurement 0, `low_cnt` <= 0, stay in LOW. This is the `umbral` = 0 case and repeats every 2**WIDTH cycles.
  - On rise: emit measurement `low_cnt`, `high_cnt` <= 1, go to HIGH.
- **FSM state HIGH:**
  - Each cycle with `s_pwm` = 1: `high_cnt` increments, saturating.
  - When `high_cnt` reaches 2**WIDTH-1: `o_err` <= 1. The generator never stays high this long.
  - On fall: `low_cnt` <= 1, `high_cnt` <= 0, go to LOW.
- **Emit measurement v:**
  - Registered: `o_umbral` <= v, `o_valid` <= 1 for exactly one cycle, `o_locked` <= 1, `o_err` <= 0.
  - `o_valid` is 0 in every cycle without an emit.
- **Latency:** raw `i_pwm` rising transition to `o_valid` high = SYNC_STAGES + 2 clock edges.
  - Recovered value equals the number of low clocks exactly. Synchronizer delay cancels because both edges see the same delay.
- **Width rules:**
  - `low_cnt` never exceeds 2**WIDTH-1; the stuck-low wrap is the emit-0 event, not an overflow.
  - `high_cnt` saturates and never wraps.
- **Simultaneous events:** rise and fall are mutually exclusive by construction. A stuck-low emit and a rise cannot coincide, because the emit requires `s_pwm` = 0.
- **Reset mid-operation:** every output and state is cleared immediately (asynchronous). The first post-reset measurement requires a complete low phase to be observed; a partial phase in progress at reset release is never reported.
- **Glitches:** a single-cycle low pulse after synchronization is a real measurement of 1; no filtering is performed.

Test Plan:
- Generator model with `umbral` = 100, period 4096, reset released mid-high phase -> first `o_valid` with `o_umbral` = 100 after the first complete low phase; then exactly one `o_valid` per 4096 cycles, value 100; `o_locked` = 1, `o_err` = 0.
- `umbral` = 0 (constant low) from reset -> `o_valid` with `o_umbral` = 0 after 4096 low cycles, then every 4096 cycles; `o_locked` = 1.
- `umbral` = 4095 then `umbral` = 1 -> `o_umbral` reports 4095, then 1 on the first period after the change; `o_valid` always exactly one cycle wide.
- Change `umbral` 100 -> 2000 mid-period -> at most one transitional value, then steady 2000; no missing or double `o_valid` in steady state.
- Hold `i_pwm` high for 5000 cycles after lock -> `o_err` = 1 from high cycle 4095 (plus synchronizer delay); next complete low phase of 300 -> `o_umbral` = 300, `o_err` cleared with that `o_valid`.
- Assert `i_reset_n` = 0 mid low phase, release -> all outputs 0 immediately; partial low phase not reported; first `o_valid` only after the next full low phase, with the correct value.
